// File: rtl/chunk_drawer_if.sv
`default_nettype none
// ============================================================================
// Module   : chunk_drawer_if
// Brief    : Memory read-port and framebuffer write-port bundle for chunk_drawer.
// Revision : 1.0
// ============================================================================
interface chunk_drawer_if;
    logic       load;
    logic [1:0] cell_in;
    logic [5:0] draw_x_chunk;
    logic [4:0] draw_y_chunk;
    logic       draw_done;
    logic [9:0] x;
    logic [8:0] y;
    logic       pixel_color;
    logic       plot;
    logic       busy;

    modport master (
        input  load, cell_in,
        output draw_x_chunk, draw_y_chunk, draw_done,
        output x, y, pixel_color, plot, busy
    );

    modport slave (
        output load, cell_in,
        input  draw_x_chunk, draw_y_chunk, draw_done,
        input  x, y, pixel_color, plot, busy
    );
endinterface
`default_nettype wire

// File: rtl/chunk_drawer.sv
`default_nettype none
// ============================================================================
// Module   : chunk_drawer
// Brief    : Sweeps the chunk grid row-major and paints each cell as a square.
//            Optional macro DRAW_GRIDLINES_EN blacks out the px==0 / py==0 pixels.
// Revision : 1.0
// ============================================================================
module chunk_drawer #(
    parameter int CHUNK_PIX = 16,
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30
) (
    input  wire logic      clk,
    input  wire logic      reset,
    chunk_drawer_if.master bus
);
    localparam int PXW = $clog2(CHUNK_PIX);
    localparam logic [PXW-1:0] c_px_last = PXW'(CHUNK_PIX - 1);
    localparam logic [5:0]     c_gx_last = 6'(GRID_W - 1);
    localparam logic [4:0]     c_gy_last = 5'(GRID_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PAINT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     chunk_x_q, chunk_x_d;
    logic [4:0]     chunk_y_q, chunk_y_d;
    logic [PXW-1:0] px_q, px_d;
    logic [PXW-1:0] py_q, py_d;
    logic           cell_q, cell_d;

    logic w_in_paint;
    logic w_color;
    logic w_unused_cell_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            chunk_x_q <= '0;
            chunk_y_q <= '0;
            px_q      <= '0;
            py_q      <= '0;
            cell_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            chunk_x_q <= chunk_x_d;
            chunk_y_q <= chunk_y_d;
            px_q      <= px_d;
            py_q      <= py_d;
            cell_q    <= cell_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        chunk_x_d = chunk_x_q;
        chunk_y_d = chunk_y_q;
        px_d      = px_q;
        py_d      = py_q;
        cell_d    = cell_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    state_d   = S_FETCH;
                    chunk_x_d = '0;
                    chunk_y_d = '0;
                    px_d      = '0;
                    py_d      = '0;
                end
            end
            S_FETCH: begin
                // The colour is frozen here so memory writes during PAINT cannot leak in.
                cell_d  = bus.cell_in[0];
                px_d    = '0;
                py_d    = '0;
                state_d = S_PAINT;
            end
            S_PAINT: begin
                if (px_q == c_px_last) begin
                    px_d = '0;
                    if (py_q == c_px_last) begin
                        py_d = '0;
                        if (chunk_x_q == c_gx_last && chunk_y_q == c_gy_last) begin
                            state_d = S_DONE;
                        end else if (chunk_x_q == c_gx_last) begin
                            chunk_x_d = '0;
                            chunk_y_d = chunk_y_q + 5'd1;
                            state_d   = S_FETCH;
                        end else begin
                            chunk_x_d = chunk_x_q + 6'd1;
                            state_d   = S_FETCH;
                        end
                    end else begin
                        py_d = py_q + 1'b1;
                    end
                end else begin
                    px_d = px_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                chunk_x_d = '0;
                chunk_y_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_in_paint = (state_q == S_PAINT);

`ifdef DRAW_GRIDLINES_EN
    assign w_color = cell_q & (px_q != '0) & (py_q != '0);
`else
    assign w_color = cell_q;
`endif

    assign w_unused_cell_bit = bus.cell_in[1];

    assign bus.draw_x_chunk = chunk_x_q;
    assign bus.draw_y_chunk = chunk_y_q;
    assign bus.x            = 10'(chunk_x_q) * 10'(CHUNK_PIX) + 10'(px_q);
    assign bus.y            = 9'(chunk_y_q) * 9'(CHUNK_PIX) + 9'(py_q);
    assign bus.plot         = w_in_paint;
    assign bus.pixel_color  = w_in_paint & w_color;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.draw_done    = (state_q == S_DONE);

endmodule
`default_nettype wire
